reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Scoreboard on the writer side of the register-dependence interface. It records every in-flight register write when the instruction issues from ID, and clears it when that write retires from WB. It drives the ID-stage stall directly from per-register pending counts, so it replaces per-stage destination comparison and supports pipelines of any depth or variable latency between issue and writeback.

Parameters:
NUM_REGS, 16, number of architectural registers; one pending counter per register.
REG_W, 4, register-ID width; NUM_REGS must equal 2**REG_W.
CNT_W, 2, pending-counter width; allows up to 2**CNT_W-1 in-flight writes to one register.
RETIRE_BYPASS, 0, if 1 a same-cycle retire counts against the stall check.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
src1  input  REG_W  ID-stage source register 1
src2  input  REG_W  ID-stage source register 2
use_src1  input  1  ID instruction reads src1
Two_src  input  1  ID instruction reads src2
id_valid  input  1  ID holds a real instruction (not a bubble)
freeze  input  1  external pipeline freeze (memory wait); blocks issue
issue_dest  input  REG_W  destination register of the ID instruction
issue_WB_EN  input  1  ID instruction writes issue_dest
wb_valid  input  1  WB stage holds a real instruction
wb_dest  input  REG_W  destination being written back
wb_WB_EN  input  1  WB instruction writes wb_dest
hazard_detected  output  1  stall ID/IF and insert a bubble into EXE
issue_fire  output  1  ID instruction accepted this cycle
pending_mask  output  NUM_REGS  bit r set when count[r] is not 0
sb_error  output  1  sticky: counter overflow or underflow

Behaviour:
- Reset (asynchronous, immediate): all counters are 0, sb_error=0, pending_mask=0. hazard_detected and issue_fire follow combinationally from zero counts, so with zero counts both are governed only by the inputs.
- Effective count eff(r) = count[r]. If RETIRE_BYPASS=1 and a retire to r is happening this cycle, eff(r) = count[r]-1.
- hazard_detected is combinational, with no added latency:
  - (use_src1 && eff(src1)!=0) || (Two_src && eff(src2)!=0).
  - Gated by id_valid: it is 0 when id_valid=0.
- issue_fire = id_valid && !freeze && !hazard_detected.
- issue = issue_fire && issue_WB_EN. retire = wb_valid && wb_WB_EN.
- Counter update on the clk rising edge, per register r:
  - issue only to r: +1.
  - retire only to r: -1.
  - issue and retire both to r: no change.
- The stall check uses counts from before the current issue. An instruction whose dest equals its src does not stall on itself.
- With RETIRE_BYPASS=0, a retire is visible to the stall check one cycle after the WB edge. This is a conservative one-cycle extra stall.
- Overflow: an issue to r with count[r]=2**CNT_W-1 and no simultaneous retire to r.
  - The counter saturates (holds its value) and sb_error is set.
  - hazard_detected stays correct, because the count is nonzero.
- Underflow: a retire to r with count[r]=0 and no simultaneous issue to r.
  - The counter holds at 0 and sb_error is set.
- sb_error is cleared only by rst.
- freeze=1 blocks issue but not retire; counts may drop while frozen.
- Reset mid-operation: all pending state is discarded. The pipeline is reset by the same rst, so no stale retires follow.
- pending_mask is registered-derived: the OR-reduction of each counter, with no bypass.

Decomposition:
- Shared package holds REG_W, NUM_REGS, the register-ID typedef, and the CNT_W default. The register-ID typedef is shared with the hazard/forwarding logic and the pipeline registers.
- One natural sub-module: sb_counter, a single-register up/down saturating counter.
  - Inputs: inc, dec.
  - Outputs: nonzero, ovf, unf.
  - Instantiated NUM_REGS times by a generate loop.
- The top level holds issue/retire decode, the stall OR-tree, and the sticky error.

Test Plan:
- Basic RAW: issue dest=3 WB_EN=1, next cycle src1=3 use_src1=1.
  - Required: hazard_detected=1 and issue_fire=0 until the retire of r3.
  - With RETIRE_BYPASS=0: the cycle after that retire, hazard_detected=0 and issue_fire=1.
- Self-reference: src1=5, dest=5, count[5]=0 -> hazard_detected=0, issue_fire=1. Next cycle pending_mask[5]=1.
- Two_src gating: count[7]=1, src2=7.
  - Two_src=0 -> hazard_detected=0.
  - Two_src=1 -> hazard_detected=1.
  - id_valid=0 -> hazard_detected=0.
- Simultaneous issue and retire of r2 with count[2]=1 -> count[2] stays 1, pending_mask[2]=1, sb_error=0.
- Multiple in-flight writes to r4:
  - Three issues to r4 -> count 3.
  - A fourth issue -> count stays 3, sb_error=1.
  - Three retires -> pending_mask[4]=0.
  - A fourth retire -> count stays 0, sb_error remains 1.
- Reset mid-operation: counts r1=2 and r9=1, assert rst asynchronously between edges.
  - Required: pending_mask=0 and sb_error=0 immediately, before the next clk edge.
  - After rst is released, src1=1 -> hazard_detected=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: register-ID width, register count and pending-counter width
// shared by the scoreboard, hazard/forwarding logic and pipeline registers.
package reg_scoreboard_pkg;
    localparam int REG_W    = 4;
    localparam int NUM_REGS = 2**REG_W;
    localparam int CNT_W    = 2;
    typedef logic [REG_W-1:0] reg_id_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID-stage issue, WB-stage retire and stall/status signals.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;
    reg_id_t               src1;
    reg_id_t               src2;
    logic                  use_src1;
    logic                  Two_src;
    logic                  id_valid;
    logic                  freeze;
    reg_id_t               issue_dest;
    logic                  issue_WB_EN;
    logic                  wb_valid;
    reg_id_t               wb_dest;
    logic                  wb_WB_EN;
    logic                  hazard_detected;
    logic                  issue_fire;
    logic [NUM_REGS-1:0]   pending_mask;
    logic                  sb_error;
    modport master (
        output src1, src2, use_src1, Two_src, id_valid, freeze, issue_dest, issue_WB_EN,
               wb_valid, wb_dest, wb_WB_EN,
        input  hazard_detected, issue_fire, pending_mask, sb_error
    );
    modport slave (
        input  src1, src2, use_src1, Two_src, id_valid, freeze, issue_dest, issue_WB_EN,
               wb_valid, wb_dest, wb_WB_EN,
        output hazard_detected, issue_fire, pending_mask, sb_error
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: per-register saturating up/down count of in-flight writes;
// an overflowing or underflowing step holds the count and is flagged.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nonzero,
    output logic o_multi,
    output logic o_ovf,
    output logic o_unf
);
    logic [W-1:0] r_cnt;
    always_comb begin
        o_nonzero = |r_cnt;
        o_multi   = r_cnt > W'(1);
        o_ovf     = i_inc && !i_dec && (&r_cnt);
        o_unf     = i_dec && !i_inc && !(|r_cnt);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_inc && !i_dec && !o_ovf)
            r_cnt <= r_cnt + W'(1);
        else if (i_dec && !i_inc && !o_unf)
            r_cnt <= r_cnt - W'(1);
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks pending register writes from ID issue to WB retire and
// stalls ID while any read source still has a write in flight.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int RETIRE_BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    reg_scoreboard_if.slave   sb
);
    logic                w_issue;
    logic                w_retire;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_nz;
    logic [NUM_REGS-1:0] w_multi;
    logic [NUM_REGS-1:0] w_ovf;
    logic [NUM_REGS-1:0] w_unf;
    logic [NUM_REGS-1:0] w_eff;
    logic                r_err;
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_cnt
            assign w_inc[g] = w_issue && (sb.issue_dest == reg_id_t'(g));
            assign w_dec[g] = w_retire && (sb.wb_dest == reg_id_t'(g));
            // with bypass, a retiring count of exactly one no longer blocks
            assign w_eff[g] = (RETIRE_BYPASS != 0 && w_dec[g]) ? w_multi[g] : w_nz[g];
            sb_counter #(.W(CNT_W)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .i_inc    (w_inc[g]),
                .i_dec    (w_dec[g]),
                .o_nonzero(w_nz[g]),
                .o_multi  (w_multi[g]),
                .o_ovf    (w_ovf[g]),
                .o_unf    (w_unf[g])
            );
        end
    endgenerate
    always_comb begin
        sb.hazard_detected = sb.id_valid &&
            ((sb.use_src1 && w_eff[sb.src1]) || (sb.Two_src && w_eff[sb.src2]));
        sb.issue_fire      = sb.id_valid && !sb.freeze && !sb.hazard_detected;
        w_issue            = sb.issue_fire && sb.issue_WB_EN;
        w_retire           = sb.wb_valid && sb.wb_WB_EN;
        sb.pending_mask    = w_nz;
        sb.sb_error        = r_err;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (|(w_ovf | w_unf))
            r_err <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed stimulus pushes expected outputs into a queue;
// a negedge monitor pops and compares against the DUT each cycle.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    reg_scoreboard_if sb();
    reg_scoreboard dut (.clk(clk), .rst(rst), .sb(sb));
    typedef struct {
        string               name;
        logic                hz;
        logic                fire;
        logic [NUM_REGS-1:0] mask;
        logic                err;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    task automatic idle();
        sb.src1 = '0; sb.src2 = '0; sb.use_src1 = 1'b0; sb.Two_src = 1'b0;
        sb.id_valid = 1'b0; sb.freeze = 1'b0; sb.issue_dest = '0; sb.issue_WB_EN = 1'b0;
        sb.wb_valid = 1'b0; sb.wb_dest = '0; sb.wb_WB_EN = 1'b0;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask
    task automatic iss(input reg_id_t d);
        sb.id_valid = 1'b1; sb.issue_dest = d; sb.issue_WB_EN = 1'b1;
    endtask
    task automatic ret(input reg_id_t d);
        sb.wb_valid = 1'b1; sb.wb_dest = d; sb.wb_WB_EN = 1'b1;
    endtask
    task automatic rd(input reg_id_t s1, input logic u1, input reg_id_t s2, input logic t2);
        sb.id_valid = 1'b1; sb.src1 = s1; sb.use_src1 = u1; sb.src2 = s2; sb.Two_src = t2;
    endtask
    task automatic exp_push(input string n, input logic hz, input logic fire,
                            input logic [NUM_REGS-1:0] mask, input logic err);
        exp_t e;
        e.name = n; e.hz = hz; e.fire = fire; e.mask = mask; e.err = err;
        q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (sb.hazard_detected !== e.hz || sb.issue_fire !== e.fire ||
                sb.pending_mask !== e.mask || sb.sb_error !== e.err) begin
                failures++;
                $display("FAIL %s: got hz=%b fire=%b mask=%h err=%b, required hz=%b fire=%b mask=%h err=%b",
                         e.name, sb.hazard_detected, sb.issue_fire, sb.pending_mask, sb.sb_error,
                         e.hz, e.fire, e.mask, e.err);
            end
        end
    end
    initial begin
        idle();
        @(posedge clk);
        #1;
        exp_push("reset", 0, 0, 16'h0000, 0);
        step(); rst = 1'b0;
        iss(3);                               exp_push("raw_issue", 0, 1, 16'h0000, 0);
        step(); rd(3, 1, 0, 0); iss(6);       exp_push("raw_stall", 1, 0, 16'h0008, 0);
        step(); rd(3, 1, 0, 0); iss(6); ret(3); exp_push("raw_retire_cycle", 1, 0, 16'h0008, 0);
        step(); rd(3, 1, 0, 0); iss(6);       exp_push("raw_release", 0, 1, 16'h0000, 0);
        step(); ret(6);                       exp_push("r6_pending", 0, 0, 16'h0040, 0);
        step(); rd(5, 1, 0, 0); iss(5);       exp_push("self_ref", 0, 1, 16'h0000, 0);
        step(); ret(5);                       exp_push("self_ref_mask", 0, 0, 16'h0020, 0);
        step(); iss(7);                       exp_push("r7_issue", 0, 1, 16'h0000, 0);
        step(); rd(0, 0, 7, 0);               exp_push("two_src_off", 0, 1, 16'h0080, 0);
        step(); rd(0, 0, 7, 1);               exp_push("two_src_on", 1, 0, 16'h0080, 0);
        step(); rd(0, 0, 7, 1); sb.id_valid = 1'b0; exp_push("id_invalid", 0, 0, 16'h0080, 0);
        step(); iss(8); sb.freeze = 1'b1; ret(7); exp_push("freeze_retire", 0, 0, 16'h0080, 0);
        step();                               exp_push("freeze_no_issue", 0, 0, 16'h0000, 0);
        step(); iss(2);                       exp_push("r2_issue", 0, 1, 16'h0000, 0);
        step(); iss(2); ret(2);               exp_push("r2_iss_ret", 0, 1, 16'h0004, 0);
        step(); ret(2);                       exp_push("r2_held", 0, 0, 16'h0004, 0);
        step(); iss(4);                       exp_push("r4_iss1", 0, 1, 16'h0000, 0);
        step(); iss(4);                       exp_push("r4_iss2", 0, 1, 16'h0010, 0);
        step(); iss(4);                       exp_push("r4_iss3", 0, 1, 16'h0010, 0);
        step(); iss(4);                       exp_push("r4_iss4", 0, 1, 16'h0010, 0);
        step(); ret(4);                       exp_push("r4_ovf", 0, 0, 16'h0010, 1);
        step(); ret(4);                       exp_push("r4_ret2", 0, 0, 16'h0010, 1);
        step(); ret(4);                       exp_push("r4_ret3", 0, 0, 16'h0010, 1);
        step(); ret(4);                       exp_push("r4_empty", 0, 0, 16'h0000, 1);
        step();                               exp_push("r4_unf", 0, 0, 16'h0000, 1);
        step(); iss(1);                       exp_push("r1_iss1", 0, 1, 16'h0000, 1);
        step(); iss(1);                       exp_push("r1_iss2", 0, 1, 16'h0002, 1);
        step(); iss(9);                       exp_push("r9_iss", 0, 1, 16'h0002, 1);
        step();                               exp_push("pre_reset", 0, 0, 16'h0202, 1);
        step(); rst = 1'b1;                   exp_push("async_reset", 0, 0, 16'h0000, 0);
        step(); rst = 1'b0; rd(1, 1, 0, 0);   exp_push("post_reset_r1", 0, 1, 16'h0000, 0);
        step(); rd(0, 0, 9, 1);               exp_push("post_reset_r9", 0, 1, 16'h0000, 0);
        step();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
